// File: rtl/ats21_pkg.sv
// Shared types for the ATS21 command issuer: opcodes, issuer states and
// the position of the acknowledge bit in the ATS21 status word.
package ats21_pkg;

  // ATS21 instruction opcodes carried in instruction bits [31:29].
  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_SET_CLK = 3'b001,
    OP_EN_CLK  = 3'b010,
    OP_MODE    = 3'b011,
    OP_SET_ALM = 3'b101,
    OP_SET_TMR = 3'b110,
    OP_EN_ALM  = 3'b111
  } ats21_op_e;

  // Issue-slot sequencing states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RDY,
    S_HI,
    S_LO,
    S_STAT,
    S_RESP
  } issuer_state_e;

  // Bit of statA/statB that carries the ATS21 acknowledge.
  localparam int ATS21_ACK_BIT = 0;

endpackage

// File: rtl/ats21_cmd_issuer_if.sv
// Client command/response signals plus the ATS21-facing handshake bus.
// The issuer uses the master view; the clients and ATS21 model use slave.
interface ats21_cmd_issuer_if;
  logic        cmdA_valid;
  logic [31:0] cmdA_data;
  logic        cmdA_ready;
  logic        cmdB_valid;
  logic [31:0] cmdB_data;
  logic        cmdB_ready;
  logic        rspA_valid;
  logic        rspA_ack;
  logic        rspA_tmo;
  logic        rspB_valid;
  logic        rspB_ack;
  logic        rspB_tmo;
  logic        req;
  logic        ready;
  logic [15:0] ctrlA;
  logic [15:0] ctrlB;
  logic [1:0]  statA;
  logic [1:0]  statB;

  modport master (
    input  cmdA_valid, cmdA_data, cmdB_valid, cmdB_data, ready, statA, statB,
    output cmdA_ready, cmdB_ready, rspA_valid, rspA_ack, rspA_tmo,
           rspB_valid, rspB_ack, rspB_tmo, req, ctrlA, ctrlB
  );

  modport slave (
    output cmdA_valid, cmdA_data, cmdB_valid, cmdB_data, ready, statA, statB,
    input  cmdA_ready, cmdB_ready, rspA_valid, rspA_ack, rspA_tmo,
           rspB_valid, rspB_ack, rspB_tmo, req, ctrlA, ctrlB
  );
endinterface

// File: rtl/ats21_cmd_fifo.sv
// Synchronous single-clock FIFO with registered read data. The head entry
// is copied into pop_data on the pop edge, so it is valid the cycle after.
module ats21_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] pop_data_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = pop_data_reg;
  // A full FIFO refuses the push even if the head is popped this cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Registered read of the head entry on pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_data_reg <= '0;
    end else if (do_pop) begin
      pop_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/ats21_cmd_issuer.sv
// Pairs the heads of the two client FIFOs into one issue slot, runs the
// ATS21 req/ready handshake, sends the slot as HI then LO halves, samples
// the status after a fixed latency and returns per-client responses.
module ats21_cmd_issuer
  import ats21_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int RDY_TIMEOUT = 15,
  parameter int STAT_LAT    = 2
) (
  input  logic               clk,
  input  logic               reset,
  ats21_cmd_issuer_if.master bus,
  output logic               busy
);
  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W   = 8;

  logic [1:0]              cmd_valid;
  logic [1:0][31:0]        cmd_data;
  logic [1:0]              push;
  logic [1:0]              pop;
  logic [1:0]              fifo_full;
  logic [1:0]              fifo_empty;
  logic [1:0][31:0]        head;
  logic [1:0][FIFO_CW-1:0] unused_count;
  logic                    unused_stat;

  issuer_state_e    state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       v_reg, v_next;
  logic [1:0][31:0] slot_reg, slot_next;
  logic [1:0]       ack_reg, ack_next;
  logic             tmo_reg, tmo_next;
  logic             req_reg, req_next;
  logic [1:0][15:0] ctrl_reg, ctrl_next;
  logic [1:0]       rsp_valid_reg, rsp_valid_next;
  logic [1:0]       rsp_ack_reg, rsp_ack_next;
  logic [1:0]       rsp_tmo_reg, rsp_tmo_next;
  logic             busy_reg, busy_next;

  // Index 0 is client A, index 1 is client B throughout.
  assign cmd_valid      = {bus.cmdB_valid, bus.cmdA_valid};
  assign cmd_data       = {bus.cmdB_data, bus.cmdA_data};
  assign push           = cmd_valid & ~fifo_full;
  assign bus.cmdA_ready = ~fifo_full[0];
  assign bus.cmdB_ready = ~fifo_full[1];
  // Only the acknowledge bit of each status word is meaningful here.
  assign unused_stat    = bus.statA[1] ^ bus.statB[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_client
      ats21_cmd_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push[gi]),
        .push_data (cmd_data[gi]),
        .pop       (pop[gi]),
        .pop_data  (head[gi]),
        .full      (fifo_full[gi]),
        .empty     (fifo_empty[gi]),
        .count     (unused_count[gi])
      );
    end
  endgenerate

  // State, slot, counter and registered output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      v_reg         <= '0;
      slot_reg      <= '0;
      ack_reg       <= '0;
      tmo_reg       <= 1'b0;
      req_reg       <= 1'b0;
      ctrl_reg      <= '0;
      rsp_valid_reg <= '0;
      rsp_ack_reg   <= '0;
      rsp_tmo_reg   <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      v_reg         <= v_next;
      slot_reg      <= slot_next;
      ack_reg       <= ack_next;
      tmo_reg       <= tmo_next;
      req_reg       <= req_next;
      ctrl_reg      <= ctrl_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_ack_reg   <= rsp_ack_next;
      rsp_tmo_reg   <= rsp_tmo_next;
      busy_reg      <= busy_next;
    end
  end

  // Next-state logic; outputs are derived from the next state so they are
  // registered and line up exactly with the state they belong to.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    v_next     = v_reg;
    slot_next  = slot_reg;
    ack_next   = ack_reg;
    tmo_next   = tmo_reg;
    pop        = 2'b00;

    case (state_reg)
      S_IDLE: begin
        if (!(&fifo_empty)) begin
          pop        = ~fifo_empty;
          v_next     = ~fifo_empty;
          ack_next   = 2'b00;
          tmo_next   = 1'b0;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        // FIFO read data lands this cycle; an empty side issues a NOP.
        for (int i = 0; i < 2; i++) begin
          slot_next[i] = v_reg[i] ? head[i] : 32'h0;
        end
        cnt_next   = '0;
        state_next = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (bus.ready) begin
          state_next = S_HI;
        end else if (cnt_reg == CNT_W'(RDY_TIMEOUT - 1)) begin
          tmo_next   = 1'b1;
          state_next = S_RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_HI: begin
        state_next = S_LO;
      end
      S_LO: begin
        cnt_next   = '0;
        state_next = S_STAT;
      end
      S_STAT: begin
        if (cnt_reg == CNT_W'(STAT_LAT - 1)) begin
          ack_next   = {bus.statB[ATS21_ACK_BIT], bus.statA[ATS21_ACK_BIT]};
          state_next = S_RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    req_next = (state_next == S_REQ);
    for (int i = 0; i < 2; i++) begin
      if (state_next == S_HI) begin
        ctrl_next[i] = slot_next[i][31:16];
      end else if (state_next == S_LO) begin
        ctrl_next[i] = slot_next[i][15:0];
      end else begin
        ctrl_next[i] = 16'h0;
      end
    end
    rsp_valid_next = (state_next == S_RESP) ? v_next : 2'b00;
    rsp_ack_next   = rsp_valid_next & ack_next & {2{~tmo_next}};
    rsp_tmo_next   = rsp_valid_next & {2{tmo_next}};
    busy_next      = (state_next != S_IDLE);
  end

  assign bus.req        = req_reg;
  assign bus.ctrlA      = ctrl_reg[0];
  assign bus.ctrlB      = ctrl_reg[1];
  assign bus.rspA_valid = rsp_valid_reg[0];
  assign bus.rspB_valid = rsp_valid_reg[1];
  assign bus.rspA_ack   = rsp_ack_reg[0];
  assign bus.rspB_ack   = rsp_ack_reg[1];
  assign bus.rspA_tmo   = rsp_tmo_reg[0];
  assign bus.rspB_tmo   = rsp_tmo_reg[1];
  assign busy           = busy_reg;
endmodule

// File: tb/tb_ats21_cmd_issuer.sv
// Directed bench for ats21_cmd_issuer: single and paired slots, timeout,
// FIFO full behaviour and reset in the middle of a slot.
module tb_ats21_cmd_issuer;
  logic clk;
  logic reset;
  logic busy;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  ats21_cmd_issuer_if bus ();

  ats21_cmd_issuer #(
    .FIFO_DEPTH  (4),
    .RDY_TIMEOUT (15),
    .STAT_LAT    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one push on each selected client for exactly one edge.
  task automatic push(input logic va, input logic [31:0] da, input logic vb, input logic [31:0] db);
    @(posedge clk);
    #1;
    bus.cmdA_valid = va;
    bus.cmdA_data  = da;
    bus.cmdB_valid = vb;
    bus.cmdB_data  = db;
    @(posedge clk);
    #1;
    bus.cmdA_valid = 1'b0;
    bus.cmdB_valid = 1'b0;
  endtask

  // Follow one slot with ready already high: k counts negedges after the
  // push edge; k=1 REQ, k=3 HI, k=4 LO, k=7 RESP, k=8 back in IDLE.
  task automatic run_slot(input string name, input logic [31:0] slot_a, input logic [31:0] slot_b,
                          input logic va, input logic vb, input logic acka, input logic ackb);
    logic [15:0] ea;
    logic [15:0] eb;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      ea = (k == 3) ? slot_a[31:16] : (k == 4) ? slot_a[15:0] : 16'h0;
      eb = (k == 3) ? slot_b[31:16] : (k == 4) ? slot_b[15:0] : 16'h0;
      check($sformatf("%s req k%0d", name, k), 32'(bus.req), 32'(k == 1));
      check($sformatf("%s ctrlA k%0d", name, k), 32'(bus.ctrlA), 32'(ea));
      check($sformatf("%s ctrlB k%0d", name, k), 32'(bus.ctrlB), 32'(eb));
      check($sformatf("%s rspA_valid k%0d", name, k), 32'(bus.rspA_valid), 32'((k == 7) && va));
      check($sformatf("%s rspB_valid k%0d", name, k), 32'(bus.rspB_valid), 32'((k == 7) && vb));
      check($sformatf("%s busy k%0d", name, k), 32'(busy), 32'((k >= 1) && (k <= 7)));
      if (k == 7) begin
        check($sformatf("%s rspA_ack", name), 32'(bus.rspA_ack), 32'(va && acka));
        check($sformatf("%s rspB_ack", name), 32'(bus.rspB_ack), 32'(vb && ackb));
        check($sformatf("%s rspA_tmo", name), 32'(bus.rspA_tmo), 32'(0));
        check($sformatf("%s rspB_tmo", name), 32'(bus.rspB_tmo), 32'(0));
      end
    end
    $display("txn %s: A=%h B=%h vA=%0b vB=%0b", name, slot_a, slot_b, va, vb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fill_data [5];
    logic [15:0] seen [$];
    int          n_rsp_a;
    int          n_rsp_b;
    int          n_req;
    logic        got;
    logic        tmo_seen;
    logic        ack_seen;
    logic        a_seen;

    fill_data = '{32'hA010_0001, 32'hA011_0002, 32'hA012_0003, 32'hA013_0004, 32'hA014_0005};
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    reset          = 1'b1;
    bus.cmdA_valid = 1'b0;
    bus.cmdA_data  = 32'h0;
    bus.cmdB_valid = 1'b0;
    bus.cmdB_data  = 32'h0;
    bus.ready      = 1'b1;
    bus.statA      = 2'b01;
    bus.statB      = 2'b00;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req", 32'(bus.req), 32'(0));
    check("rst ctrlA", 32'(bus.ctrlA), 32'(0));
    check("rst ctrlB", 32'(bus.ctrlB), 32'(0));
    check("rst rspA_valid", 32'(bus.rspA_valid), 32'(0));
    check("rst rspB_valid", 32'(bus.rspB_valid), 32'(0));
    check("rst rspA_ack", 32'(bus.rspA_ack), 32'(0));
    check("rst rspA_tmo", 32'(bus.rspA_tmo), 32'(0));
    check("rst busy", 32'(busy), 32'(0));
    check("rst cmdA_ready", 32'(bus.cmdA_ready), 32'(1));
    check("rst cmdB_ready", 32'(bus.cmdB_ready), 32'(1));
    reset = 1'b0;
    $display("txn reset: released");

    // Single client A, immediate ready, acknowledged.
    push(1'b1, 32'h2A00_0005, 1'b0, 32'h0);
    run_slot("single_a", 32'h2A00_0005, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Paired slot, both sides not acknowledged.
    bus.statA = 2'b00;
    bus.statB = 2'b00;
    push(1'b1, 32'hA100_0010, 1'b1, 32'hC200_0020);
    run_slot("paired", 32'hA100_0010, 32'hC200_0020, 1'b1, 1'b1, 1'b0, 1'b0);

    // Both clients issue a mode write; ATS21 acks A and nacks B.
    bus.statA = 2'b01;
    bus.statB = 2'b10;
    push(1'b1, 32'h6000_0001, 1'b1, 32'h6000_0002);
    run_slot("mode_pair", 32'h6000_0001, 32'h6000_0002, 1'b1, 1'b1, 1'b1, 1'b0);

    // Timeout: ready never rises; RESP on k=17 after 15 WAIT_RDY cycles.
    bus.ready = 1'b0;
    push(1'b1, 32'h2000_0003, 1'b0, 32'h0);
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      check($sformatf("tmo req k%0d", k), 32'(bus.req), 32'(k == 1));
      check($sformatf("tmo ctrlA k%0d", k), 32'(bus.ctrlA), 32'(0));
      check($sformatf("tmo ctrlB k%0d", k), 32'(bus.ctrlB), 32'(0));
      check($sformatf("tmo rspA_valid k%0d", k), 32'(bus.rspA_valid), 32'(k == 17));
      check($sformatf("tmo rspB_valid k%0d", k), 32'(bus.rspB_valid), 32'(0));
      if (k == 17) begin
        check("tmo rspA_tmo", 32'(bus.rspA_tmo), 32'(1));
        check("tmo rspA_ack", 32'(bus.rspA_ack), 32'(0));
      end
    end
    check("tmo busy after", 32'(busy), 32'(0));
    $display("txn timeout: A=20000003 dropped");

    // FIFO full: B holds the FSM in WAIT_RDY while A pushes five commands.
    bus.statA = 2'b01;
    bus.statB = 2'b00;
    push(1'b0, 32'h0, 1'b1, 32'h3000_0B0B);
    bus.cmdA_valid = 1'b1;
    bus.cmdA_data  = fill_data[0];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("full cmdA_ready after push %0d", i + 1), 32'(bus.cmdA_ready), 32'(i < 3));
      if (i < 4) bus.cmdA_data = fill_data[i + 1];
      else bus.cmdA_valid = 1'b0;
    end
    got      = 1'b0;
    tmo_seen = 1'b0;
    ack_seen = 1'b0;
    a_seen   = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (bus.rspB_valid) begin
        got      = 1'b1;
        tmo_seen = bus.rspB_tmo;
        ack_seen = bus.rspB_ack;
        a_seen   = bus.rspA_valid;
      end
    end
    check("full rspB seen", 32'(got), 32'(1));
    check("full rspB_tmo", 32'(tmo_seen), 32'(1));
    check("full rspB_ack", 32'(ack_seen), 32'(0));
    check("full rspA with B", 32'(a_seen), 32'(0));
    $display("txn full: B=30000B0B timed out while A queued");
    bus.ready = 1'b1;
    n_rsp_a = 0;
    n_rsp_b = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.ctrlA != 16'h0) seen.push_back(bus.ctrlA);
      if (bus.rspB_valid) n_rsp_b++;
      if (bus.rspA_valid) begin
        check($sformatf("drain ack %0d", n_rsp_a), 32'(bus.rspA_ack), 32'(1));
        n_rsp_a++;
      end
    end
    check("drain rspA count", 32'(n_rsp_a), 32'(4));
    check("drain rspB count", 32'(n_rsp_b), 32'(0));
    check("drain halves", 32'(seen.size()), 32'(8));
    for (int i = 0; i < 4; i++) begin
      if (seen.size() == 8) begin
        check($sformatf("drain hi %0d", i), 32'(seen[2 * i]), 32'(fill_data[i][31:16]));
        check($sformatf("drain lo %0d", i), 32'(seen[2 * i + 1]), 32'(fill_data[i][15:0]));
      end
    end
    check("drain busy", 32'(busy), 32'(0));
    check("drain cmdA_ready", 32'(bus.cmdA_ready), 32'(1));
    $display("txn drain: %0d A responses", n_rsp_a);

    // Reset during LO with a second command still queued behind it.
    @(posedge clk);
    #1;
    bus.cmdA_valid = 1'b1;
    bus.cmdA_data  = 32'h7000_0077;
    @(posedge clk);
    #1;
    bus.cmdA_data  = 32'h7000_0088;
    @(posedge clk);
    #1;
    bus.cmdA_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rstlo ctrlA lo", 32'(bus.ctrlA), 32'(16'h0077));
    reset = 1'b1;
    @(negedge clk);
    check("rstlo req", 32'(bus.req), 32'(0));
    check("rstlo ctrlA", 32'(bus.ctrlA), 32'(0));
    check("rstlo busy", 32'(busy), 32'(0));
    check("rstlo cmdA_ready", 32'(bus.cmdA_ready), 32'(1));
    check("rstlo rspA_valid", 32'(bus.rspA_valid), 32'(0));
    reset = 1'b0;
    n_rsp_a = 0;
    n_req   = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.rspA_valid) n_rsp_a++;
      if (bus.req) n_req++;
    end
    check("rstlo no rsp", 32'(n_rsp_a), 32'(0));
    check("rstlo fifo flushed", 32'(n_req), 32'(0));
    $display("txn reset_lo: slot abandoned, FIFO flushed");
    push(1'b1, 32'h5000_0055, 1'b0, 32'h0);
    run_slot("post_reset", 32'h5000_0055, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ats21_cmd_issuer.md
# ats21_cmd_issuer

Host-side command issuer that sits directly upstream of the ATS21 timer block. It accepts 32-bit ATS21 instructions from two independent clients (A and B) into per-client FIFOs and pairs them into one issue slot. It runs the req/ready handshake, serializes each instruction into two 16-bit halves on ctrlA/ctrlB, samples statA/statB, and returns a per-client ack/timeout response.

## Interface
- FIFO_DEPTH, 4: entries per client command FIFO (power of two, ≥2)
- RDY_TIMEOUT, 15: max cycles to wait for ready after req
- STAT_LAT, 2: cycles after the LO half before statA/statB are sampled
- clk  input  1  single clock; all logic on posedge
- reset  input  1  synchronous, active-high
- cmdA_valid / cmdB_valid  input  1  client push request
- cmdA_data / cmdB_data  input  32  ATS21 instruction; [31:29] is the opcode
- cmdA_ready / cmdB_ready  output  1  FIFO not full
- rspA_valid / rspB_valid  output  1  one-cycle response strobe
- rspA_ack / rspB_ack  output  1  1 = ATS21 acknowledged (stat bit = 1)
- rspA_tmo / rspB_tmo  output  1  1 = ready never seen, command dropped
- req  output  1  request to ATS21
- ready  input  1  ATS21 ready
- ctrlA / ctrlB  output  16  instruction halves to ATS21
- statA / statB  input  2  ATS21 status; bit 0 = Ack
- busy  output  1  FSM not in IDLE

## Operation
- Push: accepted when valid && ready. cmdX_ready = !full. Push is blocked while full even if a pop happens in the same cycle. A push and a pop in the same cycle on a non-full FIFO are both honoured.
- FSM states: IDLE, REQ, WAIT_RDY, HI, LO, STAT, RESP.
- IDLE: if either FIFO is non-empty, pop the head of each non-empty FIFO into slot registers and set slot-valid flags vA/vB, then go to REQ. An empty side gets slot = 32'h0 (NOP opcode 000).
- REQ: req=1 for exactly one cycle, then go to WAIT_RDY with the timeout counter cleared.
- WAIT_RDY: if ready=1, go to HI. Otherwise increment the counter. When counter == RDY_TIMEOUT-1 with ready still low, go to RESP with the timeout flag set.
- HI: ctrlA/ctrlB = slot[31:16]. Go to LO.
- LO: ctrlA/ctrlB = slot[15:0]. Go to STAT with the latency counter cleared.
- STAT: wait STAT_LAT cycles, then register ackA=statA[0] and ackB=statB[0], and go to RESP.
- RESP: for each side with v=1, rspX_valid=1 for one cycle, carrying rspX_ack (0 on timeout) and rspX_tmo. Sides with v=0 produce no response. Then go to IDLE.
- Opcode 011 (mode write) from both clients in the same slot is still issued; arbitration belongs to ATS21, and its Nack is reported.

## Timing
- Reset values: req=0, ctrlA=ctrlB=16'h0, rsp*_valid=0, rsp*_ack=0, rsp*_tmo=0, busy=0, cmd*_ready=1, FIFOs empty, FSM=IDLE.
- All outputs are registered.
- Latency from FIFO non-empty in IDLE to rsp strobe: 1 (IDLE) + 1 (REQ) + W (WAIT_RDY, minimum 1) + 1 (HI) + 1 (LO) + STAT_LAT + 1 (RESP). With immediate ready: 6+STAT_LAT = 8 cycles.
- ctrlA/ctrlB return to 16'h0 in every state other than HI and LO.
- Back-to-back issue: the next IDLE pop happens in the cycle after RESP. There is no overlap of slots.
- Reset asserted mid-operation: the next edge forces reset values, flushes both FIFOs, and emits no response for the in-flight slot.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.

## Structure
- ats21_pkg holds:
  - the opcode enum: NOP 000, SET_CLK 001, EN_CLK 010, MODE 011, SET_ALM 101, SET_TMR 110, EN_ALM 111
  - the issuer state enum
  - the constant ATS21_ACK_BIT=0
- Sub-module ats21_cmd_fifo (synchronous, parameterized width/depth, full/empty/count), instantiated once per client.
- The FSM, slot registers and counters live in ats21_cmd_issuer.

## Test plan
- Single client A: push 32'h2A00_0005 (SET_CLK clk5 = 5), ready high the cycle after req, statA=01 → ctrlA = 16'h2A00 then 16'h0005; ctrlB = 0 both cycles; rspA_valid with ack=1 at cycle 8; no rspB.
- Paired slot: A pushes 32'hA100_0010, B pushes 32'hC200_0020, both statuses 00 → one req; HI cycle 16'hA100/16'hC200; both rsp valid with ack=0 in the same cycle.
- Timeout: push on A, hold ready=0 → after 15 WAIT_RDY cycles, rspA_valid with tmo=1, ack=0; FSM returns to IDLE; no ctrl halves driven.
- FIFO full: push 5 commands on A without ready → cmdA_ready=0 after the 4th; the 5th is not accepted; exactly 4 responses are drained in order.
- Reset during LO: reset=1 for one cycle → req=0, ctrl=0, FIFOs empty, no rsp; a subsequent push is issued normally.
